// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin,
// LSB first, one full-subtractor cell per clock with a registered borrow.
// Valid/ready handshakes on the operand and result sides; one op in flight.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, diff_q;
  logic [WIDTH-1:0] a_shift, b_shift, diff_shift;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, d, x, y, last, bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb, ovf_q;
`endif

  // Full-subtractor cell and the shifted next values of all serial registers
  always_comb begin
    x          = a_sr[0];
    y          = b_sr[0];
    d          = x ^ y ^ br;
    br_nxt     = (~x & y) | (~(x ^ y) & br);
    a_shift    = a_sr >> 1;
    b_shift    = b_sr >> 1;
    diff_shift = diff_sr >> 1;
    // Index-assign the MSB so the WIDTH=1 case needs no special path
    diff_shift[WIDTH-1] = d;
    last       = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      diff_q  <= '0;
      cnt     <= '0;
      br      <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr    <= a_shift;
          b_sr    <= b_shift;
          diff_sr <= diff_shift;
          br      <= br_nxt;
          cnt     <= cnt + CW'(1);
          if (last) begin
            diff_q <= diff_shift;
            bout_q <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // d is the final diff MSB
            ovf_q  <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
